// File: rtl/count_event_monitor.sv
// Watches the up/down counter value, classifies each sampled transition and
// queues the resulting events for a valid/ready consumer.
module count_event_monitor #(
    parameter int FIFO_DEPTH = 4,
    parameter int THRESH_HI  = 200,
    parameter int THRESH_LO  = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mon_en,
    input  logic [7:0] count_in,
    input  logic       clr_flags,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [2:0] evt_code,
    output logic [7:0] evt_value,
    output logic       ovf_flag,
    output logic [7:0] jump_cnt
);

    localparam int             AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0]    DEPTH_C = (AW + 1)'(FIFO_DEPTH);
    localparam logic [7:0]     HI_C    = 8'(THRESH_HI);
    localparam logic [7:0]     LO_C    = 8'(THRESH_LO);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("count_event_monitor: FIFO_DEPTH must be a power of 2, at least 2");
    end
    if (THRESH_HI <= THRESH_LO) begin : g_bad_thresh
        $error("count_event_monitor: THRESH_HI must be greater than THRESH_LO");
    end

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DN   = 2'd2
    } dir_t;

    typedef enum logic [2:0] {
        EVT_NONE     = 3'd0,
        EVT_JUMP     = 3'd1,
        EVT_WRAP_UP  = 3'd2,
        EVT_WRAP_DN  = 3'd3,
        EVT_HI_CROSS = 3'd4,
        EVT_LO_CROSS = 3'd5,
        EVT_DIR_CHG  = 3'd6
    } evt_t;

    // Sampler state
    logic [7:0]  r_prev;
    logic        r_primed;
    dir_t        r_last_dir;

    // Event FIFO
    logic [2:0]  r_code_mem [FIFO_DEPTH];
    logic [7:0]  r_val_mem  [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_occ;

    // Flags
    logic        r_ovf;
    logic [7:0]  r_jump_cnt;

    logic [7:0]  w_delta;
    logic        w_sample;
    logic        w_up;
    logic        w_dn;
    logic        w_hold;
    logic        w_jump;
    logic        w_step;
    dir_t        w_step_dir;
    evt_t        w_code;
    logic        w_push;
    logic        w_pop;
    logic        w_full;
    logic        w_push_ok;
    logic        w_drop;
    logic        w_count_jump;

    assign w_delta    = count_in - r_prev;
    assign w_sample   = mon_en & r_primed;
    assign w_up       = (w_delta == 8'd1);
    assign w_dn       = (w_delta == 8'hFF);
    assign w_hold     = (w_delta == 8'd0);
    assign w_jump     = ~(w_up | w_dn | w_hold);
    assign w_step     = w_up | w_dn;
    assign w_step_dir = w_up ? DIR_UP : DIR_DN;

    // Priority order: the first matching condition is the only event reported.
    always_comb begin
        w_code = EVT_NONE;
        if (w_jump) begin
            w_code = EVT_JUMP;
        end else if (w_up && r_prev == 8'hFF) begin
            w_code = EVT_WRAP_UP;
        end else if (w_dn && r_prev == 8'h00) begin
            w_code = EVT_WRAP_DN;
        end else if (w_step && r_prev < HI_C && count_in >= HI_C) begin
            w_code = EVT_HI_CROSS;
        end else if (w_step && r_prev >= LO_C && count_in < LO_C) begin
            w_code = EVT_LO_CROSS;
        end else if (w_step && r_last_dir != DIR_NONE && r_last_dir != w_step_dir) begin
            w_code = EVT_DIR_CHG;
        end
    end

    assign w_push       = w_sample && (w_code != EVT_NONE);
    assign w_pop        = (r_occ != '0) && evt_ready;
    assign w_full       = (r_occ == DEPTH_C);
    assign w_push_ok    = w_push && (!w_full || w_pop);
    assign w_drop       = w_push && w_full && !w_pop;
    assign w_count_jump = w_sample && w_jump;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev     <= 8'd0;
            r_primed   <= 1'b0;
            r_last_dir <= DIR_NONE;
        end else if (mon_en) begin
            r_prev   <= count_in;
            r_primed <= 1'b1;
            if (w_sample && w_step) begin
                r_last_dir <= w_step_dir;
            end
        end else begin
            r_primed <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_code_mem[i] <= 3'd0;
                r_val_mem[i]  <= 8'd0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push_ok) begin
                r_code_mem[r_wr_ptr] <= w_code;
                r_val_mem[r_wr_ptr]  <= count_in;
                r_wr_ptr             <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // A same-edge set or increment takes precedence over the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf      <= 1'b0;
            r_jump_cnt <= 8'd0;
        end else begin
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (clr_flags) begin
                r_ovf <= 1'b0;
            end

            if (clr_flags) begin
                r_jump_cnt <= w_count_jump ? 8'd1 : 8'd0;
            end else if (w_count_jump && r_jump_cnt != 8'hFF) begin
                r_jump_cnt <= r_jump_cnt + 8'd1;
            end
        end
    end

    assign evt_valid = (r_occ != '0);
    assign evt_code  = evt_valid ? r_code_mem[r_rd_ptr] : 3'd0;
    assign evt_value = evt_valid ? r_val_mem[r_rd_ptr]  : 8'd0;
    assign ovf_flag  = r_ovf;
    assign jump_cnt  = r_jump_cnt;

endmodule

// File: tb/tb_count_event_monitor.sv
// Directed bench for count_event_monitor: step/hold, wraps, threshold
// crossings, direction changes, jumps, FIFO overflow and asynchronous reset.
module tb_count_event_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic       mon_en;
    logic [7:0] count_in;
    logic       clr_flags;
    logic       evt_valid;
    logic       evt_ready;
    logic [2:0] evt_code;
    logic [7:0] evt_value;
    logic       ovf_flag;
    logic [7:0] jump_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic       pr;
        logic [7:0] v;
        logic [2:0] c;
    } row_t;

    always #5 clk = ~clk;

    count_event_monitor #(
        .FIFO_DEPTH(4),
        .THRESH_HI (200),
        .THRESH_LO (50)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mon_en   (mon_en),
        .count_in (count_in),
        .clr_flags(clr_flags),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_code (evt_code),
        .evt_value(evt_value),
        .ovf_flag (ovf_flag),
        .jump_cnt (jump_cnt)
    );

    task automatic drive(input logic [7:0] v);
        count_in = v;
        @(posedge clk);
        #1;
    endtask

    // One disabled edge drops primed, the next enabled edge only captures v.
    task automatic prime(input logic [7:0] v);
        mon_en   = 1'b0;
        count_in = v;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; mon_en = 1'b0; count_in = 8'd0; clr_flags = 1'b0; evt_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (evt_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", evt_valid); else n_pass++;
        n_checks++;
        if (evt_code !== 3'd0) $display("FAIL reset_code got %0d want 0", evt_code); else n_pass++;
        n_checks++;
        if (evt_value !== 8'd0) $display("FAIL reset_value got %0d want 0", evt_value); else n_pass++;
        n_checks++;
        if (ovf_flag !== 1'b0) $display("FAIL reset_ovf got %b want 0", ovf_flag); else n_pass++;
        n_checks++;
        if (jump_cnt !== 8'd0) $display("FAIL reset_jump_cnt got %0d want 0", jump_cnt); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_step_hold();
        mon_en = 1'b1;
        for (int i = 0; i <= 11; i++) begin
            drive((i == 11) ? 8'd10 : 8'(i));
            n_checks++;
            if (evt_valid !== 1'b0) $display("FAIL step_no_event i=%0d got valid=%b want 0", i, evt_valid);
            else n_pass++;
        end
        n_checks++;
        if (jump_cnt !== 8'd0) $display("FAIL step_jump_cnt got %0d want 0", jump_cnt); else n_pass++;
    endtask

    task automatic test_wrap();
        row_t rows [8] = '{
            '{1'b1, 8'd253, 3'd0}, '{1'b0, 8'd254, 3'd0}, '{1'b0, 8'd255, 3'd0},
            '{1'b0, 8'd0,   3'd2}, '{1'b0, 8'd1,   3'd0}, '{1'b0, 8'd0,   3'd6},
            '{1'b0, 8'd255, 3'd3}, '{1'b0, 8'd254, 3'd0}
        };
        for (int i = 0; i < 8; i++) begin
            if (rows[i].pr) prime(rows[i].v);
            else drive(rows[i].v);
            n_checks++;
            if (evt_valid !== (rows[i].c != 3'd0) ||
                (rows[i].c != 3'd0 && {evt_code, evt_value} !== {rows[i].c, rows[i].v}))
                $display("FAIL wrap row=%0d got %b/%0d/%0d want %b/%0d/%0d", i, evt_valid, evt_code,
                         evt_value, rows[i].c != 3'd0, rows[i].c, rows[i].v);
            else n_pass++;
        end
    endtask

    task automatic test_threshold();
        row_t rows [14] = '{
            '{1'b1, 8'd196, 3'd0}, '{1'b0, 8'd197, 3'd6}, '{1'b0, 8'd198, 3'd0},
            '{1'b0, 8'd199, 3'd0}, '{1'b0, 8'd200, 3'd4}, '{1'b0, 8'd201, 3'd0},
            '{1'b1, 8'd53,  3'd0}, '{1'b0, 8'd52,  3'd6}, '{1'b0, 8'd51,  3'd0},
            '{1'b0, 8'd50,  3'd0}, '{1'b0, 8'd49,  3'd5}, '{1'b1, 8'd199, 3'd0},
            '{1'b0, 8'd200, 3'd4}, '{1'b0, 8'd199, 3'd6}
        };
        for (int i = 0; i < 14; i++) begin
            if (rows[i].pr) prime(rows[i].v);
            else drive(rows[i].v);
            n_checks++;
            if (evt_valid !== (rows[i].c != 3'd0) ||
                (rows[i].c != 3'd0 && {evt_code, evt_value} !== {rows[i].c, rows[i].v}))
                $display("FAIL thresh row=%0d got %b/%0d/%0d want %b/%0d/%0d", i, evt_valid, evt_code,
                         evt_value, rows[i].c != 3'd0, rows[i].c, rows[i].v);
            else n_pass++;
        end
    endtask

    task automatic test_jump();
        prime(8'd10);
        drive(8'd40);
        n_checks++;
        if ({evt_valid, evt_code, evt_value} !== {1'b1, 3'd1, 8'd40})
            $display("FAIL jump_event got %b/%0d/%0d want 1/1/40", evt_valid, evt_code, evt_value);
        else n_pass++;
        n_checks++;
        if (jump_cnt !== 8'd1) $display("FAIL jump_cnt_one got %0d want 1", jump_cnt); else n_pass++;
        // last_dir is still DN from the threshold run; a jump must not alter it
        drive(8'd39);
        n_checks++;
        if (evt_valid !== 1'b0) $display("FAIL jump_keeps_dir got valid=%b want 0", evt_valid); else n_pass++;
        for (int i = 0; i < 300; i++) drive((i % 2 == 0) ? 8'd0 : 8'd128);
        n_checks++;
        if (jump_cnt !== 8'd255) $display("FAIL jump_cnt_sat got %0d want 255", jump_cnt); else n_pass++;
        clr_flags = 1'b1;
        drive(8'd128);
        n_checks++;
        if (jump_cnt !== 8'd0) $display("FAIL jump_cnt_clr got %0d want 0", jump_cnt); else n_pass++;
        drive(8'd0);
        n_checks++;
        if (jump_cnt !== 8'd1) $display("FAIL jump_cnt_clr_and_jump got %0d want 1", jump_cnt); else n_pass++;
        clr_flags = 1'b0;
        n_checks++;
        if (ovf_flag !== 1'b0) $display("FAIL ovf_before_full got %b want 0", ovf_flag); else n_pass++;
    endtask

    task automatic test_overflow();
        logic [7:0] fill [5] = '{8'd0, 8'd255, 8'd0, 8'd255, 8'd0};
        logic [2:0] dr_c [5] = '{3'd3, 3'd2, 3'd3, 3'd3, 3'd0};
        logic [7:0] dr_v [5] = '{8'd255, 8'd0, 8'd255, 8'd255, 8'd0};
        prime(8'd255);
        evt_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(fill[i]);
            n_checks++;
            if ({evt_valid, evt_code, evt_value} !== {1'b1, 3'd2, 8'd0})
                $display("FAIL ovf_head_stable i=%0d got %b/%0d/%0d want 1/2/0", i, evt_valid, evt_code, evt_value);
            else n_pass++;
            n_checks++;
            if (ovf_flag !== (i == 4)) $display("FAIL ovf_flag i=%0d got %b want %b", i, ovf_flag, i == 4);
            else n_pass++;
        end
        // Full FIFO: pop the head and push a WRAP_DN on the same edge
        evt_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(8'd255);
            n_checks++;
            if (evt_valid !== (dr_c[i] != 3'd0) ||
                (dr_c[i] != 3'd0 && {evt_code, evt_value} !== {dr_c[i], dr_v[i]}))
                $display("FAIL drain i=%0d got %b/%0d/%0d want %b/%0d/%0d", i, evt_valid, evt_code, evt_value,
                         dr_c[i] != 3'd0, dr_c[i], dr_v[i]);
            else n_pass++;
        end
        n_checks++;
        if (ovf_flag !== 1'b1) $display("FAIL ovf_sticky got %b want 1", ovf_flag); else n_pass++;
        clr_flags = 1'b1;
        drive(8'd255);
        clr_flags = 1'b0;
        n_checks++;
        if (ovf_flag !== 1'b0) $display("FAIL ovf_clr got %b want 0", ovf_flag); else n_pass++;
        evt_ready = 1'b0;
        for (int i = 0; i < 4; i++) drive(fill[i]);
        clr_flags = 1'b1;
        drive(8'd0);
        clr_flags = 1'b0;
        n_checks++;
        if (ovf_flag !== 1'b1) $display("FAIL ovf_clr_and_drop got %b want 1", ovf_flag); else n_pass++;
    endtask

    task automatic test_reset_mid();
        evt_ready = 1'b1;
        drive(8'd0);
        evt_ready = 1'b0;
        n_checks++;
        if ({evt_valid, evt_code, evt_value} !== {1'b1, 3'd3, 8'd255})
            $display("FAIL pre_reset_head got %b/%0d/%0d want 1/3/255", evt_valid, evt_code, evt_value);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (evt_valid !== 1'b0) $display("FAIL async_reset_valid got %b want 0", evt_valid); else n_pass++;
        n_checks++;
        if ({ovf_flag, jump_cnt} !== {1'b0, 8'd0})
            $display("FAIL async_reset_flags got %b/%0d want 0/0", ovf_flag, jump_cnt);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        evt_ready = 1'b1;
        drive(8'd77);
        n_checks++;
        if (evt_valid !== 1'b0) $display("FAIL first_sample_after_reset got valid=%b want 0", evt_valid); else n_pass++;
        drive(8'd78);
        n_checks++;
        if (evt_valid !== 1'b0) $display("FAIL dir_none_after_reset got valid=%b want 0", evt_valid); else n_pass++;
        drive(8'd77);
        n_checks++;
        if ({evt_valid, evt_code, evt_value} !== {1'b1, 3'd6, 8'd77})
            $display("FAIL dir_chg_after_reset got %b/%0d/%0d want 1/6/77", evt_valid, evt_code, evt_value);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_step_hold();
        test_wrap();
        test_threshold();
        test_jump();
        test_overflow();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/count_event_monitor.md
Name: count_event_monitor

Overview:
- Downstream consumer of the 8-bit up/down counter output.
- Samples `count` every clock and classifies each transition: step, hold, wrap, threshold crossing, direction change or illegal jump.
- Queues classified events in a small FIFO and presents them on a valid/ready port to the checker/logging logic.
- Keeps a saturating jump-error counter and a sticky overflow flag.

Parameters:
- FIFO_DEPTH, 4, event FIFO entries; must be a power of 2, at least 2.
- THRESH_HI, 200, upper threshold; must be greater than THRESH_LO.
- THRESH_LO, 50, lower threshold.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst  input  1  reset, asynchronous and active-high.
- mon_en  input  1  monitor enable.
- count_in  input  8  counter value from up_down_counter.
- clr_flags  input  1  synchronous clear of ovf_flag and jump_cnt.
- evt_valid  output  1  FIFO head holds an event.
- evt_ready  input  1  consumer accepts the head event.
- evt_code  output  3  event code at FIFO head.
- evt_value  output  8  count_in value captured with the event.
- ovf_flag  output  1  sticky: an event was dropped because the FIFO was full.
- jump_cnt  output  8  saturating count of JUMP events.

Behaviour:
- Reset state: evt_valid=0, evt_code=0, evt_value=0, ovf_flag=0, jump_cnt=0, FIFO empty, prev=0, primed=0, last_dir=NONE.
- Reset mid-operation clears everything immediately (asynchronous), including queued events.
- Sampling:
  - At each rising edge with mon_en=1: prev<=count_in and primed<=1.
  - If primed=0 at that edge, no event is generated (first sample only).
  - With mon_en=0: primed<=0, no events; FIFO still drains normally.
- Classification: d = count_in - prev, mod 256.
  - d=0 is HOLD: no event.
  - d=1 is an UP step; d=255 is a DN step.
  - Any other d is JUMP.
- Event codes:
  - 1 JUMP.
  - 2 WRAP_UP: prev=255 and count_in=0.
  - 3 WRAP_DN: prev=0 and count_in=255.
  - 4 HI_CROSS: prev<THRESH_HI and count_in>=THRESH_HI, on a step.
  - 5 LO_CROSS: prev>=THRESH_LO and count_in<THRESH_LO, on a step.
  - 6 DIR_CHG: step direction differs from last_dir and last_dir is not NONE.
- Direction tracking: last_dir is updated on every UP/DN step; it is unchanged on HOLD and JUMP.
- One event per edge: if several conditions hold, only the lowest code is enqueued. Priority is JUMP > WRAP > HI/LO > DIR_CHG; the others are discarded silently.
- Every JUMP increments jump_cnt, saturating at 255, regardless of FIFO state.
- FIFO:
  - Circular buffer with read/write pointers and an occupancy count.
  - Push and pop occur at the same edge.
  - An event enqueued at edge N into an empty FIFO gives evt_valid=1 after edge N, with code/value stable.
  - A pop happens when evt_valid and evt_ready are both 1 at an edge.
  - Full with no pop: the new event is dropped and ovf_flag<=1.
  - Full with a simultaneous pop: the push is accepted, occupancy is unchanged, no overflow.
  - Empty: evt_ready is ignored.
  - evt_code and evt_value must not change while evt_valid=1 and evt_ready=0.
- clr_flags=1 clears ovf_flag and jump_cnt at the edge. If a JUMP or a drop happens in that same edge, the set/increment wins: jump_cnt=1, ovf_flag=1.

Test Plan:
- Reset, mon_en=1, count 0→1→…→10, evt_ready=1 → no events, jump_cnt=0.
- Count up 253,254,255,0,1 → exactly one event {2,0}; then down 1,0,255 → {6,0}, then {3,255}.
- Count 198,199,200,201 → one {4,200}; later 51,50,49 → one {5,49}; 200→199 with last_dir=UP → {6,199}.
- count_in 10 then 40 → {1,40}, jump_cnt=1; 255 consecutive jumps → jump_cnt holds at 255; clr_flags → 0.
- evt_ready=0, generate 5 WRAP events with FIFO_DEPTH=4 → 4 queued, ovf_flag=1; release evt_ready → codes drain in order; a push on the same edge as a pop while full is accepted.
- Assert rst with 3 events queued → evt_valid=0 immediately; after release, the first sample creates no event even if count_in jumped.
